// File: rtl/arb_frame_tx.sv
// -----------------------------------------------------------------------------
// arb_frame_tx
//
// Serial frame transmitter that sits behind a two-requester arbiter. When a
// grant arrives, the granted master's payload is latched and sent on a single
// shared UART-style line: one start bit (0), eight data bits LSB first, and
// one stop bit (1). Each bit lasts BAUD_DIV clock cycles. At the end of the
// frame a one-cycle done strobe goes back to the owning master so it can drop
// its request. This releases the arbiter for the other side.
//
// Grant/done handshake: a grant seen in IDLE is accepted at that edge and
// owned until the frame ends. The owner then gets exactly one done pulse. The
// block waits in RELEASE until the owner's grant is sampled low, so a grant
// that is held on never retransmits the same payload. Grants from the other
// master are ignored until IDLE.
//
// Parameters:
//   BAUD_DIV     clock cycles per serial bit (2..65535)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   gnt1, gnt2   arbiter grants (gnt1 wins if both are high)
//   data1, data2 payloads, sampled only at frame acceptance
//   tx           serial line, idles high
//   busy         high from acceptance until the return to IDLE
//   owner        one-hot frame owner (01 = master 1, 10 = master 2)
//   done1, done2 one-cycle completion strobes
//   dbg_state_o  current FSM state, for checkers
// -----------------------------------------------------------------------------
module arb_frame_tx #(
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gnt1,
  input  logic       gnt2,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic       tx,
  output logic       busy,
  output logic [1:0] owner,
  output logic       done1,
  output logic       done2,
  output logic [2:0] dbg_state_o
);

  if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud_div
    $error("arb_frame_tx: BAUD_DIV must be in 2..65535");
  end

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e      state_q,   state_d;
  logic [7:0]  shift_q,   shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_q,    baud_d;
  logic        tx_q,      tx_d;
  logic        busy_q,    busy_d;
  logic [1:0]  owner_q,   owner_d;
  logic        done1_q,   done1_d;
  logic        done2_q,   done2_d;

  logic baud_end;
  logic owner_gnt;

  // The last cycle of the current bit period.
  assign baud_end  = (baud_q == BAUD_LAST);
  // The current owner's grant is still asserted.
  assign owner_gnt = (owner_q[0] & gnt1) | (owner_q[1] & gnt2);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      owner_q   <= 2'b00;
      done1_q   <= 1'b0;
      done2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      done1_q   <= done1_d;
      done2_q   <= done2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    // Done strobes last one cycle. They are only raised at the end of STOP.
    done1_d   = 1'b0;
    done2_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        owner_d   = 2'b00;
        baud_d    = 16'd0;
        bit_cnt_d = 3'd0;
        // Master 1 has priority in case both grants are high at once.
        if (gnt1) begin
          shift_d = data1;
          owner_d = 2'b01;
        end else if (gnt2) begin
          shift_d = data2;
          owner_d = 2'b10;
        end
        // The start bit begins at the same edge that accepts the frame.
        if (gnt1 || gnt2) begin
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d    = 16'd0;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // shift_q[0] is the bit on the line now. The next bit is shift_q[1].
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          done1_d = owner_q[0];
          done2_d = owner_q[1];
          state_d = S_RELEASE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_RELEASE: begin
        // Hold here until the owner lets go. Otherwise a grant that stays
        // high would resend the same payload.
        if (!owner_gnt) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          owner_d = 2'b00;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        owner_d = 2'b00;
        baud_d  = 16'd0;
      end
    endcase
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign done1       = done1_q;
  assign done2       = done2_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arb_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_arb_frame_tx
//
// Directed bench for arb_frame_tx (BAUD_DIV = 4). A table of single-frame
// vectors is applied in a loop. Hand-written sequences cover idle behaviour,
// reset in the middle of a frame, and a full request/grant loop through a
// small arbiter model.
// -----------------------------------------------------------------------------
module tb_arb_frame_tx;

  localparam int B = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       gnt1_drv, gnt2_drv;
  logic [7:0] data1, data2;
  logic       gnt1, gnt2;
  logic       tx, busy, done1, done2;
  logic [1:0] owner;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  // Arbiter-loop model: the masters hold their requests until done. The
  // arbiter keeps a grant until its request drops, and master 1 has priority.
  logic loop_go;
  logic req1, req2, arb_g1, arb_g2;

  always @(posedge clk) begin
    if (!loop_go) begin
      req1 <= 1'b1;
      req2 <= 1'b1;
    end else begin
      if (done1) req1 <= 1'b0;
      if (done2) req2 <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!loop_go) begin
      arb_g1 <= 1'b0;
      arb_g2 <= 1'b0;
    end else if (!arb_g1 && !arb_g2) begin
      if (req1)      arb_g1 <= 1'b1;
      else if (req2) arb_g2 <= 1'b1;
    end else if (arb_g1 && !req1) begin
      arb_g1 <= 1'b0;
    end else if (arb_g2 && !req2) begin
      arb_g2 <= 1'b0;
    end
  end

  assign gnt1 = loop_go ? arb_g1 : gnt1_drv;
  assign gnt2 = loop_go ? arb_g2 : gnt2_drv;

  arb_frame_tx #(.BAUD_DIV(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .gnt1        (gnt1),
    .gnt2        (gnt2),
    .data1       (data1),
    .data2       (data2),
    .tx          (tx),
    .busy        (busy),
    .owner       (owner),
    .done1       (done1),
    .done2       (done2),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until busy reaches lvl. Counts as one comparison and is bounded.
  task automatic wait_busy(input logic lvl, input string nm);
    int n;
    n = 0;
    while (busy !== lvl && n < 60) begin
      tick();
      n++;
    end
    check(nm, busy, lvl);
  endtask

  // Call this just after the acceptance edge k. It checks every cycle of the
  // frame and returns just after edge k+10*B, where the done pulse must show.
  // With swap_mid set, the grants are exchanged and the payload inputs are
  // inverted partway through the frame. Neither change may affect the frame.
  task automatic check_frame(input logic [1:0] exp_owner, input logic [7:0] exp_data,
                             input logic swap_mid);
    logic [9:0] fr;
    fr = {1'b1, exp_data, 1'b0};
    for (int cyc = 0; cyc < 10 * B; cyc++) begin
      check("frame_tx", tx, fr[cyc / B]);
      check("frame_busy", busy, 1'b1);
      check("frame_owner", owner, exp_owner);
      check("frame_no_done", {done2, done1}, 2'b00);
      if (swap_mid && cyc == 2 * B) begin
        gnt1_drv = ~gnt1_drv;
        gnt2_drv = ~gnt2_drv;
        data1    = ~data1;
        data2    = ~data2;
      end
      tick();
    end
    check("done_pulse", {done2, done1}, {exp_owner[1], exp_owner[0]});
    check("done_tx_idle", tx, 1'b1);
    check("done_busy", busy, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       g1;
    logic       g2;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       swap;
    int         hold;
    logic [1:0] own;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic run_frame(input vec_t v);
    gnt1_drv = v.g1;
    gnt2_drv = v.g2;
    data1    = v.d1;
    data2    = v.d2;
    tick();
    check_frame(v.own, v.exp, v.swap);
    if (v.swap) begin
      gnt1_drv = 1'b0;
      gnt2_drv = 1'b0;
    end
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check("hold_busy", busy, 1'b1);
      check("hold_owner", owner, v.own);
      check("hold_tx", tx, 1'b1);
      check("hold_no_done", {done2, done1}, 2'b00);
    end
    gnt1_drv = 1'b0;
    gnt2_drv = 1'b0;
    tick();
    check("rel_busy", busy, 1'b0);
    check("rel_owner", owner, 2'b00);
    check("rel_done_cleared", {done2, done1}, 2'b00);
    check("rel_tx", tx, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    //          g1    g2    d1     d2     swap  hold  own    exp
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 0,    2'b01, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h01, 8'hFF, 1'b0, 0,    2'b01, 8'h01};
    vecs[2] = '{0,    1'b1, 8'hEE, 8'h96, 1'b0, 0,    2'b10, 8'h96};
    vecs[3] = '{1'b1, 1'b0, 8'h3C, 8'h5A, 1'b1, 0,    2'b01, 8'h3C};
    vecs[4] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 15,   2'b01, 8'h81};
    vecs[5] = '{0,    1'b1, 8'hFF, 8'h00, 1'b0, 0,    2'b10, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 0,    2'b01, 8'hFF};

    loop_go  = 1'b0;
    rst      = 1'b1;
    gnt1_drv = 1'b0;
    gnt2_drv = 1'b0;
    data1    = 8'h00;
    data2    = 8'h00;
    repeat (3) tick();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_owner", owner, 2'b00);
    check("reset_done", {done2, done1}, 2'b00);
    rst = 1'b0;

    // No grants for 20 cycles: the line stays idle.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_owner", owner, 2'b00);
      check("idle_done", {done2, done1}, 2'b00);
    end

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset during the 4th data bit. The frame is abandoned with no done pulse.
    gnt1_drv = 1'b1;
    data1    = 8'hF0;
    tick();
    check("rstmid_accept", busy, 1'b1);
    for (int i = 0; i < 4 * B + 1; i++) tick();
    rst = 1'b1;
    tick();
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_owner", owner, 2'b00);
    check("rstmid_done", {done2, done1}, 2'b00);
    rst      = 1'b0;
    gnt1_drv = 1'b0;
    for (int i = 0; i < 8 * B; i++) begin
      tick();
      check("post_rst_done", {done2, done1}, 2'b00);
      check("post_rst_tx", tx, 1'b1);
    end
    run_frame('{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 0, 2'b10, 8'h55});

    // Full request/grant loop through the arbiter model.
    data1   = 8'h3C;
    data2   = 8'hC3;
    loop_go = 1'b1;
    wait_busy(1'b1, "loop_first_accept");
    check_frame(2'b01, 8'h3C, 1'b0);
    tick();
    check("loop_done1_single", {done2, done1}, 2'b00);
    wait_busy(1'b0, "loop_release");
    // The next grant can only be accepted at the following edge.
    check("loop_idle_gap_owner", owner, 2'b00);
    wait_busy(1'b1, "loop_second_accept");
    check_frame(2'b10, 8'hC3, 1'b0);
    tick();
    check("loop_done2_single", {done2, done1}, 2'b00);
    wait_busy(1'b0, "loop_final_release");
    loop_go = 1'b0;
    repeat (2) tick();
    check("end_idle_tx", tx, 1'b1);
    check("end_idle_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arb_frame_tx.md
Name: arb_frame_tx

Overview:
- Downstream consumer of the two-requester ARBITER (req1/req2 -> gnt1/gnt2).
- Takes the grant lines, latches the granted master's 8-bit payload and serializes it onto one shared UART-style line: start bit, 8 data bits LSB first, stop bit.
- Pulses a per-master done strobe so that master drops its request, releasing the arbiter for the other side.
- Lets the arbiter workshop drive a real shared resource instead of bare grant LEDs.

Parameters:
- BAUD_DIV, 4, clock cycles per serial bit; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- gnt1  input  1  grant to master 1, from arbiter gnt1.
- gnt2  input  1  grant to master 2, from arbiter gnt2.
- data1  input  8  payload of master 1; sampled only at frame acceptance.
- data2  input  8  payload of master 2; sampled only at frame acceptance.
- tx  output  1  serial line; idles high.
- busy  output  1  high from frame acceptance until return to IDLE.
- owner  output  2  one-hot owner of the current frame (01 = master 1, 10 = master 2, 00 = none).
- done1  output  1  one-cycle pulse when master 1's frame completes.
- done2  output  1  one-cycle pulse when master 2's frame completes.

Behaviour:
- The clock is clk; the reset is rst, synchronous and active-high. The block has one clock.
- All outputs are registered.
- Reset values: tx=1, busy=0, owner=00, done1=0, done2=0, state=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame:
  - The frame is abandoned at the next edge; all outputs take their reset values.
  - No done pulse is issued for the abandoned frame.
- States: IDLE, START, DATA, STOP, RELEASE.
- IDLE:
  - At an edge with gnt1=1, latch data1 into the shift register and set owner=01.
  - Else, at an edge with gnt2=1, latch data2 and set owner=10.
  - If both grants are high (illegal from the arbiter), master 1 wins.
  - On either acceptance, at that same edge: state<=START, tx<=0, busy<=1, baud counter<=0.
  - With no grant: hold tx=1 and busy=0.
- START:
  - tx stays 0 for exactly BAUD_DIV cycles.
  - Then go to DATA and drive tx = shift[0].
- DATA:
  - Each bit is held BAUD_DIV cycles; then shift right and drive the next bit.
  - After the 8th bit has been held, go to STOP and drive tx=1.
- STOP:
  - tx=1 for BAUD_DIV cycles.
  - At the edge ending the stop bit: go to RELEASE and assert done1 or done2 (per owner) for exactly one cycle.
- Timing:
  - If acceptance occurs at edge k, tx falls at edge k.
  - The done pulse is registered at edge k+10*BAUD_DIV.
  - Frame length is 10*BAUD_DIV cycles.
- RELEASE:
  - Stay while the owner's grant is still high; this prevents retransmitting the same payload.
  - At the first edge where the owner's grant is sampled low: state<=IDLE, busy<=0, owner<=00.
  - There is at least one IDLE cycle between frames. A grant present in that IDLE cycle is accepted there.
- Grant dropped mid-frame: the frame still completes and done is still pulsed; the payload is already latched.
- Grant switching to the other master mid-frame: ignored until IDLE.
- data1/data2 changes after acceptance: no effect on the frame in flight.
- Counters:
  - Baud counter is 16 bits; it counts 0..BAUD_DIV-1 and wraps.
  - Bit counter is 3 bits, 0..7.
  - No other arithmetic.

Test Plan:
- Reset, then grant idle for 20 cycles -> tx=1, busy=0, owner=00, done1=done2=0 throughout.
- BAUD_DIV=4; data1=8'hA5; gnt1 high at edge k -> tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; owner=01; done1 single pulse at edge k+40; done2 stays 0.
- Full loop with ARBITER instance, req1 and req2 both high, data1=8'h3C, data2=8'hC3 -> frame 3C sent; req1 cleared on done1; arbiter grants 2; frame C3 follows after at least 1 IDLE cycle, owner=10.
- gnt1 held high 15 cycles after done1 -> block stays in RELEASE, busy=1, no second frame; gnt1 low -> busy=0 one edge later.
- gnt1 and gnt2 high simultaneously with data1=8'h01, data2=8'hFF -> frame 01 transmitted, owner=01.
- rst pulsed during the 4th data bit -> tx=1, busy=0, owner=00 at the next edge, no done pulse; a subsequent gnt2 with data2=8'h55 is sent cleanly.
